sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//  Shares one sdram_controller user port between NUM_PORTS requesters (CPU, video, DMA).
//  Accepts single-beat read/write requests per port, arbitrates, and drives the controller
//  command/address/data until completion. Returns read data and a one-cycle ready pulse.
//  Recovers from a stuck controller with a timeout.
//  Sits between the bus bridges and sdram_controller, which runs with READ_BURST_LENGTH=1.
// PARAMETERS
//  NUM_PORTS      2     number of requesters, 2..8
//  ADDR_WIDTH     24    user address width: bank+row+column
//  DATA_WIDTH     16    data width
//  FIXED_PRIO     0     0 = round-robin; 1 = lowest index always wins
//  TIMEOUT_CYCLES 1023  ISSUE cycles before abort; 0 disables the timeout
// PORTS
//  clk             in   1                     system clock, same clock as sdram_controller
//  rst_n           in   1                     asynchronous reset, active low
//  port_req        in   NUM_PORTS             request; held high until that port's ready
//  port_we         in   NUM_PORTS             1 = write, 0 = read
//  port_addr       in   NUM_PORTS*ADDR_WIDTH  per-port address, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  port_wdata      in   NUM_PORTS*DATA_WIDTH  per-port write data
//  port_ready      out  NUM_PORTS             one-cycle completion pulse, one-hot
//  port_err        out  NUM_PORTS             one-cycle timeout pulse, coincident with ready
//  port_rdata      out  DATA_WIDTH            read data, shared; valid while port_ready is high
//  mem_command     out  2                     to controller: 0 idle, 1 write, 2 read
//  mem_address     out  ADDR_WIDTH            to controller data_address
//  mem_write_data  out  DATA_WIDTH            to controller data_write
//  mem_read_data   in   DATA_WIDTH            from controller data_read
//  mem_read_valid  in   1                     from controller data_read_valid
//  mem_write_done  in   1                     from controller data_write_done
//  timeout_sticky  out  1                     set on any timeout, cleared only by reset
// BEHAVIOUR
//  - Reset (async on rst_n low, any state): state=IDLE; mem_command=0; mem_address=0;
//    mem_write_data=0; port_ready=0; port_err=0; port_rdata=0; timeout_sticky=0;
//    rr pointer=NUM_PORTS-1, so port 0 wins first; timeout counter=0.
//  - All outputs are registered. The FSM has states IDLE, ISSUE and RESP.
//  - IDLE: if any port_req is set, pick a winner.
//    - FIXED_PRIO=1: the lowest index wins.
//    - FIXED_PRIO=0: search from pointer+1 upward with wrap; pointer is set to the winner.
//    - Capture the winner's addr and wdata into mem_address and mem_write_data.
//    - Set mem_command = we ? 1 : 2, clear the counter, go to ISSUE.
//    - If no request: stay in IDLE, mem_command=0, address and data held.
//  - ISSUE: mem_command, mem_address and mem_write_data are held stable. The counter increments.
//    - Write completes when mem_write_done=1. Read completes when mem_read_valid=1;
//      port_rdata <= mem_read_data.
//    - On completion: mem_command<=0, port_ready[winner]<=1, go to RESP.
//    - Both done and valid high together: the one matching the current command counts;
//      the other is ignored.
//    - TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no completion:
//      mem_command<=0, port_ready[winner]<=1, port_err[winner]<=1, port_rdata<=0,
//      timeout_sticky<=1, go to RESP.
//    - mem_read_valid and mem_write_done outside ISSUE are ignored.
//  - RESP: one cycle. port_ready and port_err drop, go to IDLE.
//    - RESP gives the requester one edge to drop or change its req before the next arbitration.
//  - Latency: req sampled at edge N -> mem_command valid after N. The ready pulse is the
//    cycle after the controller completion strobe. Minimum back-to-back spacing per
//    request is controller latency + 2 cycles.
//  - Requester inputs are only sampled at the grant edge. Later changes do not affect the
//    transfer in flight.
//  - Dropping req before ready is illegal. The transfer still completes and ready still pulses.
//  - Reset mid-ISSUE aborts without a ready pulse; sdram_controller is not reset by rst_n.
//  - Port i never sees ready unless its req was high at the grant edge.
// TESTING
//  - Single write p0: addr=0x012345, wdata=0xBEEF; stub gives done 5 cycles after cmd=1
//    -> mem_command=1 held 5 cycles, port_ready=01 for 1 cycle. Read-back -> port_rdata=0xBEEF.
//  - RR fairness: p0 and p1 req continuously -> grants alternate 0,1,0,1.
//  - FIXED_PRIO=1 with the same stimulus -> all grants go to p0, p1 starves.
//  - Timeout: TIMEOUT_CYCLES=16, stub never completes -> after 16 ISSUE cycles mem_command=0,
//    port_ready and port_err pulse together, timeout_sticky=1, next request serviced normally.
//  - Stray strobe: mem_read_valid pulsed during IDLE and RESP -> no ready pulse, no state change.
//  - Reset mid-op: rst_n low in ISSUE -> mem_command=0 and all outputs at reset values
//    immediately, with no clock edge needed. After release, p0 is granted first.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one sdram_controller user port between NUM_PORTS single-beat requesters.
// A request is granted from IDLE, issued to the controller in ISSUE until the
// matching completion strobe (or the timeout) arrives, then acknowledged with a
// one-cycle ready pulse while the FSM passes through RESP.
//
// state | meaning
// IDLE  | no transfer in flight, arbitrate among port_req
// ISSUE | command held on the controller port, waiting for done/valid or timeout
// RESP  | ready (and err on timeout) pulse cycle; requester may drop/change req
module sdram_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS-1:0]            port_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]            port_ready,
  output logic [NUM_PORTS-1:0]            port_err,
  output logic [DATA_WIDTH-1:0]           port_rdata,
  output logic [1:0]                      mem_command,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]           mem_write_data,
  input  logic [DATA_WIDTH-1:0]           mem_read_data,
  input  logic                            mem_read_valid,
  input  logic                            mem_write_done,
  output logic                            timeout_sticky
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  // Last ISSUE count value before the transfer is abandoned; unused when the timeout is off.
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       last_grant;
  logic [31:0]            issue_cnt;
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       pick;
  logic                   pick_valid;
  logic                   cmd_done;
  logic                   timed_out;
  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = port_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = port_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Winner search: lowest index in fixed mode, otherwise from last_grant+1 upward with wrap.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (FIXED_PRIO != 0) cand = IDX_W'(k);
      else                 cand = IDX_W'((int'(last_grant) + 1 + k) % NUM_PORTS);
      if (!pick_valid && port_req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Only the strobe that matches the command in flight completes it.
  always_comb begin
    cmd_done  = ((mem_command == CMD_WRITE) && mem_write_done) ||
                ((mem_command == CMD_READ)  && mem_read_valid);
    timed_out = (TIMEOUT_CYCLES != 0) && (issue_cnt == TO_LAST);
  end

  // Arbitration FSM with registered controller-side and requester-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= IDX_W'(NUM_PORTS - 1);
      issue_cnt      <= '0;
      mem_command    <= CMD_IDLE;
      mem_address    <= '0;
      mem_write_data <= '0;
      port_ready     <= '0;
      port_err       <= '0;
      port_rdata     <= '0;
      timeout_sticky <= 1'b0;
    end else begin
      port_ready <= '0;
      port_err   <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            last_grant     <= pick;
            mem_address    <= addr_arr[pick];
            mem_write_data <= wdata_arr[pick];
            mem_command    <= port_we[pick] ? CMD_WRITE : CMD_READ;
            issue_cnt      <= '0;
            state          <= ISSUE;
          end else begin
            mem_command <= CMD_IDLE;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 32'd1;
          if (cmd_done) begin
            if (mem_command == CMD_READ) port_rdata <= mem_read_data;
            mem_command            <= CMD_IDLE;
            port_ready[last_grant] <= 1'b1;
            state                  <= RESP;
          end else if (timed_out) begin
            mem_command            <= CMD_IDLE;
            port_ready[last_grant] <= 1'b1;
            port_err[last_grant]   <= 1'b1;
            port_rdata             <= '0;
            timeout_sticky         <= 1'b1;
            state                  <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          mem_command <= CMD_IDLE;
        end
      endcase
    end
  end

endmodule
